roce_rdma_write_segmenter: RTL and testbench

- Parametrised RDMA WRITE packetiser for the RoCEv2-lite transmit path, sitting between the DMA payload source and the BTH/RETH header inserter / UDP-IP stack.
- Accepts one transfer request (length, QPN, PSN, R_Key, remote address, remote IP) and segments its payload stream into PMTU-sized packets.
- Emits one header descriptor per packet with the correct WRITE FIRST/MIDDLE/LAST/ONLY opcode, incrementing PSN, and RETH on the first packet only.
- Generalises the fixed 64-bit, single-packet minimal stack to any data width and PMTU, with multi-packet segmentation and payload error handling.

---
 rtl/roce_rdma_write_segmenter_if.sv | 64 ++++++
 rtl/roce_rdma_write_segmenter.sv | 185 ++++++++++++++++++
 tb/tb_roce_rdma_write_segmenter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roce_rdma_write_segmenter_if.sv
// Handshake bundle for the RDMA WRITE segmenter: request, payload in/out and header descriptor.
// The slave modport is the segmenter's view; master is the surrounding logic.
interface roce_rdma_write_segmenter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  s_req_valid;
    logic                  s_req_ready;
    logic [31:0]           s_req_length;
    logic [23:0]           s_req_qpn;
    logic [23:0]           s_req_psn;
    logic [31:0]           s_req_rkey;
    logic [47:0]           s_req_addr;
    logic [31:0]           s_req_ip;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;

    logic                  m_hdr_valid;
    logic                  m_hdr_ready;
    logic [7:0]            m_hdr_opcode;
    logic [23:0]           m_hdr_psn;
    logic [23:0]           m_hdr_qpn;
    logic                  m_hdr_ack_req;
    logic                  m_hdr_reth_en;
    logic [47:0]           m_hdr_reth_addr;
    logic [31:0]           m_hdr_reth_rkey;
    logic [31:0]           m_hdr_reth_length;
    logic [15:0]           m_hdr_pkt_length;
    logic [31:0]           m_hdr_ip;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    modport slave (
        input  s_req_valid, s_req_length, s_req_qpn, s_req_psn, s_req_rkey, s_req_addr, s_req_ip,
        output s_req_ready,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_hdr_valid, m_hdr_opcode, m_hdr_psn, m_hdr_qpn, m_hdr_ack_req, m_hdr_reth_en,
               m_hdr_reth_addr, m_hdr_reth_rkey, m_hdr_reth_length, m_hdr_pkt_length, m_hdr_ip,
        input  m_hdr_ready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport master (
        output s_req_valid, s_req_length, s_req_qpn, s_req_psn, s_req_rkey, s_req_addr, s_req_ip,
        input  s_req_ready,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_hdr_valid, m_hdr_opcode, m_hdr_psn, m_hdr_qpn, m_hdr_ack_req, m_hdr_reth_en,
               m_hdr_reth_addr, m_hdr_reth_rkey, m_hdr_reth_length, m_hdr_pkt_length, m_hdr_ip,
        output m_hdr_ready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/roce_rdma_write_segmenter.sv
// RoCEv2 RDMA WRITE packetiser: splits one DMA transfer into PMTU-sized packets,
// issuing a header descriptor per packet and passing the payload straight through.
module roce_rdma_write_segmenter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int PMTU_LOG2  = 10
) (
    input  logic        clk,
    input  logic        rst,
    roce_rdma_write_segmenter_if.slave bus,
    output logic [23:0] next_psn,
    output logic        busy,
    output logic        error_payload_early_termination,
    output logic        error_payload_overrun
);
    localparam int          KEEP_LOG2  = $clog2(KEEP_WIDTH);
    localparam logic [31:0] PMTU_BYTES = 32'd1 << PMTU_LOG2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam logic [7:0] OP_FIRST  = 8'h06;
    localparam logic [7:0] OP_MIDDLE = 8'h07;
    localparam logic [7:0] OP_LAST   = 8'h08;
    localparam logic [7:0] OP_ONLY   = 8'h0A;

    logic [1:0]            state;
    logic [31:0]           remaining;
    logic [15:0]           beat_cnt;
    logic [15:0]           last_beat;
    logic [KEEP_WIDTH-1:0] last_keep;

    logic [7:0]            hdr_opcode;
    logic [23:0]           hdr_psn;
    logic [23:0]           hdr_qpn;
    logic                  hdr_ack_req;
    logic                  hdr_reth_en;
    logic [47:0]           hdr_addr;
    logic [31:0]           hdr_rkey;
    logic [31:0]           hdr_length;
    logic [15:0]           hdr_pkt_length;
    logic [31:0]           hdr_ip;

    logic [31:0]           cand_rem;
    logic [23:0]           cand_psn;
    logic                  cand_first;
    logic                  cand_last;
    logic [15:0]           cand_len;
    logic [15:0]           cand_beats;
    logic [7:0]            cand_opcode;
    logic [KEEP_LOG2-1:0]  cand_tail;
    logic [KEEP_WIDTH-1:0] cand_keep;

    logic pay_fire;
    logic end_beat;
    logic early;
    logic load_hdr;

    // Next packet's header, derived either from a fresh request or from what is left of the current one.
    always_comb begin
        cand_first  = (state == ST_IDLE);
        cand_rem    = cand_first ? bus.s_req_length : remaining - 32'(hdr_pkt_length);
        cand_psn    = cand_first ? bus.s_req_psn : hdr_psn + 24'd1;
        cand_last   = (cand_rem <= PMTU_BYTES);
        cand_len    = cand_last ? cand_rem[15:0] : PMTU_BYTES[15:0];
        cand_beats  = (cand_len + 16'(KEEP_WIDTH - 1)) >> KEEP_LOG2;
        cand_tail   = cand_len[KEEP_LOG2-1:0];
        cand_keep   = (cand_tail == '0) ? '1 : ~({KEEP_WIDTH{1'b1}} << cand_tail);
        cand_opcode = OP_MIDDLE;
        if (cand_first && cand_last) cand_opcode = OP_ONLY;
        else if (cand_first)         cand_opcode = OP_FIRST;
        else if (cand_last)          cand_opcode = OP_LAST;
    end

    // Input tlast is only legitimate on the closing beat of the transfer's final packet.
    assign pay_fire = (state == ST_PAYLOAD) && bus.s_axis_tvalid && bus.m_axis_tready;
    assign end_beat = (beat_cnt == last_beat);
    assign early    = bus.s_axis_tlast && !(end_beat && hdr_ack_req);
    assign load_hdr = ((state == ST_IDLE) && bus.s_req_valid) ||
                      (pay_fire && !early && end_beat && !hdr_ack_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                           <= ST_IDLE;
            remaining                       <= '0;
            beat_cnt                        <= '0;
            last_beat                       <= '0;
            last_keep                       <= '0;
            hdr_opcode                      <= '0;
            hdr_psn                         <= '0;
            hdr_qpn                         <= '0;
            hdr_ack_req                     <= 1'b0;
            hdr_reth_en                     <= 1'b0;
            hdr_addr                        <= '0;
            hdr_rkey                        <= '0;
            hdr_length                      <= '0;
            hdr_pkt_length                  <= '0;
            hdr_ip                          <= '0;
            next_psn                        <= '0;
            error_payload_early_termination <= 1'b0;
            error_payload_overrun           <= 1'b0;
        end else begin
            error_payload_early_termination <= 1'b0;
            error_payload_overrun           <= 1'b0;

            if (load_hdr) begin
                remaining      <= cand_rem;
                hdr_psn        <= cand_psn;
                hdr_reth_en    <= cand_first;
                hdr_ack_req    <= cand_last;
                hdr_opcode     <= cand_opcode;
                hdr_pkt_length <= cand_len;
                last_beat      <= cand_beats - 16'd1;
                last_keep      <= cand_keep;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.s_req_valid) begin
                        hdr_qpn    <= bus.s_req_qpn;
                        hdr_rkey   <= bus.s_req_rkey;
                        hdr_addr   <= bus.s_req_addr;
                        hdr_length <= bus.s_req_length;
                        hdr_ip     <= bus.s_req_ip;
                        state      <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (bus.m_hdr_ready) begin
                        next_psn <= hdr_psn + 24'd1;
                        beat_cnt <= '0;
                        state    <= (hdr_pkt_length == '0) ? ST_IDLE : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_fire) begin
                        if (early) begin
                            error_payload_early_termination <= 1'b1;
                            state                           <= ST_IDLE;
                        end else if (end_beat) begin
                            if (!hdr_ack_req) begin
                                state <= ST_HDR;
                            end else if (bus.s_axis_tlast) begin
                                state <= ST_IDLE;
                            end else begin
                                error_payload_overrun <= 1'b1;
                                state                 <= ST_DRAIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    if (bus.s_axis_tvalid && bus.s_axis_tlast) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy              = (state != ST_IDLE);
    assign bus.s_req_ready   = (state == ST_IDLE);
    assign bus.s_axis_tready = (state == ST_PAYLOAD) ? bus.m_axis_tready : (state == ST_DRAIN);

    assign bus.m_hdr_valid       = (state == ST_HDR);
    assign bus.m_hdr_opcode      = hdr_opcode;
    assign bus.m_hdr_psn         = hdr_psn;
    assign bus.m_hdr_qpn         = hdr_qpn;
    assign bus.m_hdr_ack_req     = hdr_ack_req;
    assign bus.m_hdr_reth_en     = hdr_reth_en;
    assign bus.m_hdr_reth_addr   = hdr_addr;
    assign bus.m_hdr_reth_rkey   = hdr_rkey;
    assign bus.m_hdr_reth_length = hdr_length;
    assign bus.m_hdr_pkt_length  = hdr_pkt_length;
    assign bus.m_hdr_ip          = hdr_ip;

    // A truncated beat is always flagged with full byte enables since its true extent is unknown.
    assign bus.m_axis_tdata  = bus.s_axis_tdata;
    assign bus.m_axis_tvalid = (state == ST_PAYLOAD) && bus.s_axis_tvalid;
    assign bus.m_axis_tlast  = (state == ST_PAYLOAD) && (end_beat || bus.s_axis_tlast);
    assign bus.m_axis_tuser  = (state == ST_PAYLOAD) && early;
    assign bus.m_axis_tkeep  = ((state == ST_PAYLOAD) && end_beat && !early) ? last_keep : '1;
endmodule

// File: tb/tb_roce_rdma_write_segmenter.sv
// Scoreboard bench for the RDMA WRITE segmenter: a transfer-level model predicts headers,
// beats and error pulses; a negedge monitor compares whatever the DUT presents.
module tb_roce_rdma_write_segmenter;
    localparam int DW        = 64;
    localparam int KW        = 8;
    localparam int PMTU_LOG2 = 10;
    localparam int PMTU      = 1 << PMTU_LOG2;

    typedef struct {
        logic [7:0]  opcode;
        logic [23:0] psn;
        logic [15:0] len;
        logic        ack;
        logic        reth;
        logic [23:0] qpn;
        logic [47:0] addr;
        logic [31:0] rkey;
        logic [31:0] rlen;
        logic [31:0] ip;
        int          beats_before;
    } hdr_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] next_psn;
    logic        busy;
    logic        err_early;
    logic        err_over;

    roce_rdma_write_segmenter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

    roce_rdma_write_segmenter #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .PMTU_LOG2 (PMTU_LOG2)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .bus                            (bus),
        .next_psn                       (next_psn),
        .busy                           (busy),
        .error_payload_early_termination(err_early),
        .error_payload_overrun          (err_over)
    );

    always #5 clk = ~clk;

    hdr_t        hdr_q[$];
    beat_t       beat_q[$];
    logic [63:0] src_data[$];
    hdr_t        mh;
    beat_t       mb;
    int          tests = 0;
    int          fails = 0;
    int          beats_pushed = 0;
    int          beats_seen = 0;
    int          early_seen = 0;
    int          over_seen = 0;
    int          early_exp = 0;
    int          over_exp = 0;
    logic [23:0] exp_next_psn = '0;
    bit          mon_en = 1'b0;
    bit          rdy_random = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic int natBeats(input logic [31:0] len);
        longint rem;
        int     n;
        int     pl;
        rem = len;
        n   = 0;
        while (rem > 0) begin
            pl  = (rem > PMTU) ? PMTU : int'(rem);
            n  += (pl + KW - 1) / KW;
            rem -= pl;
        end
        return n;
    endfunction

    // Walks the transfer packet by packet, consuming source beats until the rules end it.
    task automatic buildModel(input logic [31:0] len, input logic [23:0] psn, input logic [23:0] qpn,
                              input logic [31:0] rkey, input logic [47:0] addr, input logic [31:0] ip,
                              input int nsrc);
        longint      rem;
        logic [23:0] p;
        bit          first;
        bit          done;
        bit          lastpkt;
        int          k;
        int          pl;
        int          nb;
        int          m;
        hdr_t        h;
        beat_t       b;
        rem       = len;
        p         = psn;
        first     = 1'b1;
        done      = 1'b0;
        k         = 0;
        early_exp = 0;
        over_exp  = 0;
        while (!done) begin
            pl      = (rem > PMTU) ? PMTU : int'(rem);
            nb      = (pl + KW - 1) / KW;
            lastpkt = (rem == pl);
            h.opcode       = first ? (lastpkt ? 8'h0A : 8'h06) : (lastpkt ? 8'h08 : 8'h07);
            h.psn          = p;
            h.len          = 16'(pl);
            h.ack          = lastpkt;
            h.reth         = first;
            h.qpn          = qpn;
            h.addr         = addr;
            h.rkey         = rkey;
            h.rlen         = len;
            h.ip           = ip;
            h.beats_before = beats_pushed;
            hdr_q.push_back(h);
            exp_next_psn = p + 24'd1;
            for (int bi = 1; bi <= nb; bi++) begin
                b.data = src_data[k];
                if (k == nsrc - 1 && !(bi == nb && lastpkt)) begin
                    b.keep = 8'hFF;
                    b.last = 1'b1;
                    b.user = 1'b1;
                    beat_q.push_back(b);
                    beats_pushed++;
                    early_exp = 1;
                    done      = 1'b1;
                    break;
                end
                m      = pl % KW;
                b.keep = (bi == nb && m != 0) ? 8'((16'h1 << m) - 16'h1) : 8'hFF;
                b.last = (bi == nb);
                b.user = 1'b0;
                beat_q.push_back(b);
                beats_pushed++;
                k++;
            end
            if (!done) begin
                if (pl == 0) begin
                    done = 1'b1;
                end else begin
                    rem  -= pl;
                    p     = p + 24'd1;
                    first = 1'b0;
                    if (rem == 0) begin
                        if (k < nsrc) over_exp = 1;
                        done = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic sendBeats(input int n);
        bit hs;
        int cyc;
        for (int k = 0; k < n; k++) begin
            while (rdy_random && $urandom_range(0, 3) == 0) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = src_data[k];
            bus.s_axis_tlast  = (k == n - 1);
            hs  = 1'b0;
            cyc = 0;
            while (!hs && cyc < 5000) begin
                @(negedge clk);
                hs = bus.s_axis_tready;
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!hs) begin
                reportTimeout("source_beat");
                break;
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // Issues one request and its source stream, then waits for the DUT to settle and checks totals.
    task automatic applyStimulus(input logic [31:0] len, input logic [23:0] psn, input logic [23:0] qpn,
                                 input logic [31:0] rkey, input logic [47:0] addr, input logic [31:0] ip,
                                 input int nsrc);
        bit hs;
        int cyc;
        src_data.delete();
        for (int k = 0; k < nsrc; k++) src_data.push_back({$urandom, $urandom});
        buildModel(len, psn, qpn, rkey, addr, ip, nsrc);
        early_seen = 0;
        over_seen  = 0;

        bus.s_req_valid  = 1'b1;
        bus.s_req_length = len;
        bus.s_req_psn    = psn;
        bus.s_req_qpn    = qpn;
        bus.s_req_rkey   = rkey;
        bus.s_req_addr   = addr;
        bus.s_req_ip     = ip;
        hs  = 1'b0;
        cyc = 0;
        while (!hs && cyc < 100) begin
            @(negedge clk);
            hs = bus.s_req_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.s_req_valid = 1'b0;
        if (!hs) reportTimeout("request_accept");

        sendBeats(nsrc);

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((busy || hdr_q.size() != 0 || beat_q.size() != 0) && cyc < 5000);
        if (cyc >= 5000) begin
            reportTimeout("transfer_done");
            hdr_q.delete();
            beat_q.delete();
        end
        @(negedge clk);
        checkOutput("next_psn", 64'(next_psn), 64'(exp_next_psn));
        checkOutput("early_term_pulses", 64'(early_seen), 64'(early_exp));
        checkOutput("overrun_pulses", 64'(over_seen), 64'(over_exp));
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_req_ready"}, 64'(bus.s_req_ready), 64'd1);
        checkOutput({tag, "_m_hdr_valid"}, 64'(bus.m_hdr_valid), 64'd0);
        checkOutput({tag, "_m_hdr_fields"},
                    64'(bus.m_hdr_opcode) | 64'(bus.m_hdr_psn) | 64'(bus.m_hdr_pkt_length) |
                    64'(bus.m_hdr_qpn) | 64'(bus.m_hdr_reth_length) | 64'(bus.m_hdr_ip), 64'd0);
        checkOutput({tag, "_m_axis_ctrl"},
                    64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.s_axis_tready}), 64'd0);
        checkOutput({tag, "_next_psn"}, 64'(next_psn), 64'd0);
        checkOutput({tag, "_busy_err"}, 64'({busy, err_early, err_over}), 64'd0);
    endtask

    // Header fields are compared on every cycle they are offered, so they must hold until accepted.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.m_hdr_valid) begin
                if (hdr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_header: got psn 0x%0h, expected none", bus.m_hdr_psn);
                end else begin
                    mh = hdr_q[0];
                    checkOutput("hdr_opcode", 64'(bus.m_hdr_opcode), 64'(mh.opcode));
                    checkOutput("hdr_psn", 64'(bus.m_hdr_psn), 64'(mh.psn));
                    checkOutput("hdr_pkt_length", 64'(bus.m_hdr_pkt_length), 64'(mh.len));
                    checkOutput("hdr_ack_req", 64'(bus.m_hdr_ack_req), 64'(mh.ack));
                    checkOutput("hdr_reth_en", 64'(bus.m_hdr_reth_en), 64'(mh.reth));
                    checkOutput("hdr_qpn", 64'(bus.m_hdr_qpn), 64'(mh.qpn));
                    checkOutput("hdr_ip", 64'(bus.m_hdr_ip), 64'(mh.ip));
                    if (mh.reth) begin
                        checkOutput("hdr_reth_addr", 64'(bus.m_hdr_reth_addr), 64'(mh.addr));
                        checkOutput("hdr_reth_rkey", 64'(bus.m_hdr_reth_rkey), 64'(mh.rkey));
                        checkOutput("hdr_reth_length", 64'(bus.m_hdr_reth_length), 64'(mh.rlen));
                    end
                    if (bus.m_hdr_ready) begin
                        checkOutput("hdr_after_prev_beats", 64'(beats_seen), 64'(mh.beats_before));
                        void'(hdr_q.pop_front());
                    end
                end
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (beat_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected none", bus.m_axis_tdata);
                end else begin
                    mb = beat_q.pop_front();
                    checkOutput("beat_data", bus.m_axis_tdata, mb.data);
                    checkOutput("beat_keep", 64'(bus.m_axis_tkeep), 64'(mb.keep));
                    checkOutput("beat_last", 64'(bus.m_axis_tlast), 64'(mb.last));
                    checkOutput("beat_user", 64'(bus.m_axis_tuser), 64'(mb.user));
                    beats_seen++;
                end
            end
            if (err_early) early_seen++;
            if (err_over)  over_seen++;
        end
    end

    initial begin
        bus.m_hdr_ready   = 1'b1;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) begin
                bus.m_hdr_ready   = ($urandom_range(0, 2) != 0);
                bus.m_axis_tready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.m_hdr_ready   = 1'b1;
                bus.m_axis_tready = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        tests++;
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [31:0] len;
        int          nat;
        int          nsrc;
        int          mode;
        int          cyc;

        bus.s_req_valid   = 1'b0;
        bus.s_req_length  = '0;
        bus.s_req_qpn     = '0;
        bus.s_req_psn     = '0;
        bus.s_req_rkey    = '0;
        bus.s_req_addr    = '0;
        bus.s_req_ip      = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        rdy_random = 1'b0;
        applyStimulus(32'd128, 24'd302, 24'h16, 32'hDEFE, 48'h0000_1234_5000, 32'h0BD4_0116, 16);
        applyStimulus(32'd2500, 24'd10, 24'h16, 32'hDEFE, 48'h0000_1234_6000, 32'h0BD4_0116, 313);
        applyStimulus(32'd2048, 24'hFFFFFF, 24'h22, 32'h1111, 48'hABCD_0000_0000, 32'h0A00_0001, 256);
        applyStimulus(32'd2048, 24'd500, 24'h33, 32'h2222, 48'h0000_0000_1000, 32'h0A00_0002, 50);
        rdy_random = 1'b1;
        applyStimulus(32'd64, 24'd77, 24'h44, 32'h3333, 48'h0000_0000_2000, 32'h0A00_0003, 12);
        applyStimulus(32'd0, 24'd900, 24'h55, 32'h4444, 48'h0000_0000_3000, 32'h0A00_0004, 0);
        applyStimulus(32'd2500, 24'hFFFFFE, 24'h66, 32'h5555, 48'h0000_0000_4000, 32'h0A00_0005, 313);

        for (int t = 0; t < 8; t++) begin
            len  = 32'($urandom_range(0, 3000));
            nat  = natBeats(len);
            mode = $urandom_range(0, 3);
            nsrc = nat;
            if (nat > 0 && mode == 0)      nsrc = $urandom_range(1, nat);
            else if (nat > 0 && mode == 1) nsrc = nat + $urandom_range(1, 4);
            rdy_random = ($urandom_range(0, 1) == 1);
            applyStimulus(len, 24'($urandom), 24'($urandom), $urandom, {$urandom, 16'($urandom)},
                          $urandom, nsrc);
        end

        // Reset in the middle of a payload stream must leave nothing behind.
        mon_en     = 1'b0;
        rdy_random = 1'b0;
        bus.s_req_valid  = 1'b1;
        bus.s_req_length = 32'd2048;
        bus.s_req_psn    = 24'd5;
        @(posedge clk);
        #1;
        bus.s_req_valid   = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 64'hDEAD_BEEF_0000_0001;
        bus.s_axis_tlast  = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.m_axis_tvalid && cyc < 100);
        if (!bus.m_axis_tvalid) reportTimeout("reach_payload");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_payload_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("post_reset_quiet", 64'({bus.m_hdr_valid, bus.m_axis_tvalid, busy}), 64'd0);
        end
        bus.s_axis_tvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
